// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } dec_state_t;

endpackage

// File: rtl/scancode_to_ascii.sv
// Set-2 scan code to ASCII lookup: uppercase letters, digits and space; anything else maps to 8'h00.
module scancode_to_ascii (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h41; 8'h32: ascii = 8'h42; 8'h21: ascii = 8'h43; 8'h23: ascii = 8'h44;
      8'h24: ascii = 8'h45; 8'h2B: ascii = 8'h46; 8'h34: ascii = 8'h47; 8'h33: ascii = 8'h48;
      8'h43: ascii = 8'h49; 8'h3B: ascii = 8'h4A; 8'h42: ascii = 8'h4B; 8'h4B: ascii = 8'h4C;
      8'h3A: ascii = 8'h4D; 8'h31: ascii = 8'h4E; 8'h44: ascii = 8'h4F; 8'h4D: ascii = 8'h50;
      8'h15: ascii = 8'h51; 8'h2D: ascii = 8'h52; 8'h1B: ascii = 8'h53; 8'h2C: ascii = 8'h54;
      8'h3C: ascii = 8'h55; 8'h2A: ascii = 8'h56; 8'h1D: ascii = 8'h57; 8'h22: ascii = 8'h58;
      8'h35: ascii = 8'h59; 8'h1A: ascii = 8'h5A;
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32; 8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35; 8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38; 8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops PS/2 scan-code bytes from the receiver FIFO, folds F0/E0 prefixes and tracks the held key.
// Optional ASCII lookup of the held key is built when SCANCODE_ASCII_EN is defined.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ACK_GAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic [CNT_W-1:0] press_count,
  output logic             event_valid,
  output logic             err_ovf
);

  localparam int unsigned GAP_W = (ACK_GAP > 1) ? $clog2(ACK_GAP) : 1;

  dec_state_t       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             nextdata_n_d;
  logic [7:0]       key_code_d;
  logic             key_ext_d;
  logic             key_down_d;
  logic [CNT_W-1:0] press_count_d;
  logic             event_valid_d;
  logic             err_ovf_d;
  logic             same_key_c;
  logic [7:0]       ascii_c;

`ifdef SCANCODE_ASCII_EN
  logic [7:0] rom_c;
  logic [7:0] key_ascii_d;

  scancode_to_ascii u_ascii (
    .code  (byte_q),
    .ascii (rom_c)
  );

  // Extended codes have no printable mapping.
  assign ascii_c = ext_q ? 8'h00 : rom_c;
`else
  assign ascii_c   = 8'h00;
  assign key_ascii = 8'h00;
`endif

  assign same_key_c = key_down && ({ext_q, byte_q} == {key_ext, key_code});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_q      <= 8'h00;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      gap_q       <= '0;
      nextdata_n  <= 1'b1;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_down    <= 1'b0;
      press_count <= '0;
      event_valid <= 1'b0;
      err_ovf     <= 1'b0;
`ifdef SCANCODE_ASCII_EN
      key_ascii   <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      gap_q       <= gap_d;
      nextdata_n  <= nextdata_n_d;
      key_code    <= key_code_d;
      key_ext     <= key_ext_d;
      key_down    <= key_down_d;
      press_count <= press_count_d;
      event_valid <= event_valid_d;
      err_ovf     <= err_ovf_d;
`ifdef SCANCODE_ASCII_EN
      key_ascii   <= key_ascii_d;
`endif
    end
  end

  // Next-state and next-output logic; the pop strobe is registered so it is low during POP.
  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    brk_d         = brk_q;
    ext_d         = ext_q;
    gap_d         = gap_q;
    nextdata_n_d  = 1'b1;
    key_code_d    = key_code;
    key_ext_d     = key_ext;
    key_down_d    = key_down;
    press_count_d = press_count;
    event_valid_d = 1'b0;
    err_ovf_d     = err_ovf | overflow;
`ifdef SCANCODE_ASCII_EN
    key_ascii_d   = key_ascii;
`endif

    case (state_q)
      IDLE: begin
        if (ready) begin
          byte_d       = data;
          nextdata_n_d = 1'b0;
          state_d      = POP;
        end
      end
      POP: begin
        state_d = GAP;
        gap_d   = '0;
        if (byte_q == PS2_BREAK) begin
          brk_d = 1'b1;
        end else if (byte_q == PS2_EXT) begin
          ext_d = 1'b1;
        end else if (brk_q) begin
          if (same_key_c) begin
            key_down_d    = 1'b0;
            event_valid_d = 1'b1;
          end
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else begin
          // A make of the held key is a typematic repeat and changes nothing.
          if (!same_key_c) begin
            key_code_d    = byte_q;
            key_ext_d     = ext_q;
            key_down_d    = 1'b1;
            press_count_d = CNT_W'(press_count + CNT_W'(1));
            event_valid_d = 1'b1;
`ifdef SCANCODE_ASCII_EN
            key_ascii_d   = ascii_c;
`endif
          end
          ext_d = 1'b0;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(ACK_GAP - 1)) state_d = IDLE;
        else                              gap_d   = GAP_W'(gap_q + GAP_W'(1));
      end
      default: state_d = IDLE;
    endcase
  end

  logic unused_c;
  assign unused_c = ^ascii_c;

endmodule
